asrm_int_arbiter: RTL and testbench

Collects up to 16 asynchronous peripheral interrupt lines, synchronizes them, latches edge- or level-type requests, and maps each source onto one of the four interrupt levels. It drives the `ext_int[3:0]` inputs of the CPU interrupt handler. Software configures it and claims requests through a small register port. Sources sharing a level are served round-robin through per-level CLAIM registers.

---
 rtl/asrm_int_arbiter.sv | 147 ++++++++++++++
 tb/tb_asrm_int_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asrm_int_arbiter.sv
// Interrupt arbiter: synchronizes 16 peripheral lines, latches edge/level requests,
// maps each source onto one of four CPU interrupt levels with round-robin claim registers.
module asrm_int_arbiter #(
    parameter int unsigned Wordsize = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [15:0]         src_i,
    input  logic [3:0]          addr_i,
    input  logic [Wordsize-1:0] wdata_i,
    input  logic                we_i,
    input  logic                re_i,
    output logic [Wordsize-1:0] rdata_o,
    output logic [3:0]          ext_int_o
);

    logic [15:0] s1_q, s2_q, s3_q;
    logic [15:0] enable_q, enable_d;
    logic [15:0] mode_q, mode_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] map_lo_q, map_lo_d;
    logic [15:0] map_hi_q, map_hi_d;
    logic [3:0]  rr_q [4];
    logic [3:0]  rr_d [4];
    logic [Wordsize-1:0] rdata_q, rdata_d;

    logic [31:0] map_all;
    logic [1:0]  lvl [16];
    logic [15:0] elig [4];
    logic [3:0]  found;
    logic [3:0]  win [4];

    assign map_all = {map_hi_q, map_lo_q};

    always_comb begin
        for (int n = 0; n < 16; n++) begin
            lvl[n] = map_all[2*n +: 2];
        end
        for (int l = 0; l < 4; l++) begin
            for (int n = 0; n < 16; n++) begin
                elig[l][n] = enable_q[n] & pend_q[n] & (lvl[n] == 2'(l));
            end
            ext_int_o[l] = |elig[l];
        end
    end

    // First eligible source at or after rr, wrapping 15 -> 0.
    always_comb begin
        logic [3:0] idx;
        idx = '0;
        for (int l = 0; l < 4; l++) begin
            found[l] = 1'b0;
            win[l]   = '0;
            for (int i = 0; i < 16; i++) begin
                idx = rr_q[l] + 4'(i);
                if (!found[l] && elig[l][idx]) begin
                    found[l] = 1'b1;
                    win[l]   = idx;
                end
            end
        end
    end

    always_comb begin
        logic [15:0] wr16;
        logic [15:0] rd16;
        logic [15:0] clr;
        logic [1:0]  cl;
        enable_d = enable_q;
        mode_d   = mode_q;
        map_lo_d = map_lo_q;
        map_hi_d = map_hi_q;
        rr_d     = rr_q;
        rdata_d  = rdata_q;
        wr16     = wdata_i[15:0];
        rd16     = '0;
        clr      = '0;
        cl       = 2'(addr_i - 4'd5);

        if (we_i) begin
            case (addr_i)
                4'd0:    enable_d = wr16;
                4'd1:    mode_d   = wr16;
                4'd2:    clr      = wr16;
                4'd3:    map_lo_d = wr16;
                4'd4:    map_hi_d = wr16;
                default: ;
            endcase
        end

        if (re_i) begin
            case (addr_i)
                4'd0: rd16 = enable_q;
                4'd1: rd16 = mode_q;
                4'd2: rd16 = pend_q;
                4'd3: rd16 = map_lo_q;
                4'd4: rd16 = map_hi_q;
                4'd5, 4'd6, 4'd7, 4'd8: begin
                    if (found[cl]) begin
                        rd16          = {1'b1, 11'b0, win[cl]};
                        rr_d[cl]      = win[cl] + 4'd1;
                        clr[win[cl]]  = 1'b1;
                    end
                end
                default: rd16 = '0;
            endcase
            rdata_d        = '0;
            rdata_d[15:0]  = rd16;
        end

        // Edge bits: new edge beats any clear. Level bits simply track the synchronizer.
        pend_d = (mode_q & ((pend_q & ~clr) | (s2_q & ~s3_q))) | (~mode_q & s2_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            map_lo_q <= '0;
            map_hi_q <= '0;
            rdata_q  <= '0;
            for (int l = 0; l < 4; l++) begin
                rr_q[l] <= '0;
            end
        end else begin
            s1_q     <= src_i;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            map_lo_q <= map_lo_d;
            map_hi_q <= map_hi_d;
            rdata_q  <= rdata_d;
            for (int l = 0; l < 4; l++) begin
                rr_q[l] <= rr_d[l];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_asrm_int_arbiter.sv
// Directed bench for asrm_int_arbiter: edge/level capture, claims, round-robin, masking,
// clear/set race and asynchronous reset.
module tb_asrm_int_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] src;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] rdata;
    logic [3:0]  ext_int;

    int tests;
    int fails;

    asrm_int_arbiter #(.Wordsize(16)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .src_i    (src),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .we_i     (we),
        .re_i     (re),
        .rdata_o  (rdata),
        .ext_int_o(ext_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic pulse(input logic [15:0] mask);
        @(negedge clk);
        src = src | mask;
        repeat (3) @(negedge clk);
        src = src & ~mask;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [15:0] d;
        repeat (3) @(negedge clk);
        if (ext_int !== 4'h0) begin
            $display("FAIL reset_ext_int got %h want 0", ext_int); fails++;
        end
        tests++;
        if (rdata !== 16'h0) begin
            $display("FAIL reset_rdata got %h want 0", rdata); fails++;
        end
        tests++;
        rst_n = 1'b1;
        for (int a = 0; a < 5; a++) begin
            read_reg(4'(a), d);
            if (d !== 16'h0) begin
                $display("FAIL reset_reg%0d got %h want 0", a, d); fails++;
            end
            tests++;
        end
    endtask

    task automatic test_edge;
        logic [15:0] d;
        write_reg(4'd0, 16'h0001);
        write_reg(4'd1, 16'h0001);
        write_reg(4'd3, 16'h0000);
        @(negedge clk);
        src[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (ext_int !== 4'h0) begin
            $display("FAIL edge_latency_early got %h want 0", ext_int); fails++;
        end
        tests++;
        @(posedge clk);
        #1;
        if (ext_int !== 4'h1) begin
            $display("FAIL edge_latency got %h want 1", ext_int); fails++;
        end
        tests++;
        @(negedge clk);
        src[0] = 1'b0;
        read_reg(4'd5, d);
        if (d !== 16'h8000) begin
            $display("FAIL edge_claim0 got %h want 8000", d); fails++;
        end
        tests++;
        if (ext_int !== 4'h0) begin
            $display("FAIL edge_after_claim got %h want 0", ext_int); fails++;
        end
        tests++;
        read_reg(4'd5, d);
        if (d !== 16'h0000) begin
            $display("FAIL edge_claim_empty got %h want 0000", d); fails++;
        end
        tests++;
    endtask

    task automatic test_level;
        logic [15:0] d;
        write_reg(4'd0, 16'h0020);
        write_reg(4'd1, 16'h0000);
        write_reg(4'd3, 16'h0800);
        @(negedge clk);
        src[5] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (ext_int !== 4'h4) begin
            $display("FAIL level_req got %h want 4", ext_int); fails++;
        end
        tests++;
        read_reg(4'd7, d);
        if (d !== 16'h8005) begin
            $display("FAIL level_claim2 got %h want 8005", d); fails++;
        end
        tests++;
        if (ext_int !== 4'h4) begin
            $display("FAIL level_hold got %h want 4", ext_int); fails++;
        end
        tests++;
        @(negedge clk);
        src[5] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (ext_int !== 4'h0) begin
            $display("FAIL level_drop got %h want 0", ext_int); fails++;
        end
        tests++;
    endtask

    task automatic test_round_robin;
        logic [15:0] d;
        logic [15:0] exp_ids [4];
        exp_ids[0] = 16'h8001; exp_ids[1] = 16'h8003;
        exp_ids[2] = 16'h800E; exp_ids[3] = 16'h8001;
        write_reg(4'd0, 16'h400A);
        write_reg(4'd1, 16'h400A);
        write_reg(4'd3, 16'h0044);
        write_reg(4'd4, 16'h1000);
        pulse(16'h400A);
        if (ext_int !== 4'h2) begin
            $display("FAIL rr_ext_int got %h want 2", ext_int); fails++;
        end
        tests++;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) pulse(16'h400A);
            read_reg(4'd6, d);
            if (d !== exp_ids[k]) begin
                $display("FAIL rr_claim%0d got %h want %h", k, d, exp_ids[k]); fails++;
            end
            tests++;
        end
        write_reg(4'd2, 16'hFFFF);
        read_reg(4'd2, d);
        if (d !== 16'h0000) begin
            $display("FAIL rr_pending_clear got %h want 0000", d); fails++;
        end
        tests++;
    endtask

    task automatic test_mask;
        logic [15:0] d;
        write_reg(4'd0, 16'h0204);
        write_reg(4'd1, 16'h0204);
        write_reg(4'd3, 16'h0000);
        write_reg(4'd4, 16'h000C);
        pulse(16'h0204);
        if (ext_int !== 4'h9) begin
            $display("FAIL mask_both got %h want 9", ext_int); fails++;
        end
        tests++;
        write_reg(4'd0, 16'h0200);
        if (ext_int !== 4'h8) begin
            $display("FAIL mask_disable got %h want 8", ext_int); fails++;
        end
        tests++;
        read_reg(4'd2, d);
        if (d !== 16'h0204) begin
            $display("FAIL mask_pending got %h want 0204", d); fails++;
        end
        tests++;
        write_reg(4'd2, 16'h0204);
        if (ext_int !== 4'h0) begin
            $display("FAIL mask_w1c got %h want 0", ext_int); fails++;
        end
        tests++;
    endtask

    task automatic test_race;
        logic [15:0] d;
        write_reg(4'd0, 16'h0010);
        write_reg(4'd1, 16'h0010);
        @(negedge clk);
        src[4] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        we = 1'b1; addr = 4'd2; wdata = 16'h0010;
        @(negedge clk);
        we = 1'b0;
        read_reg(4'd2, d);
        if (d !== 16'h0010) begin
            $display("FAIL race_set_wins got %h want 0010", d); fails++;
        end
        tests++;
        write_reg(4'd2, 16'h0010);
        read_reg(4'd2, d);
        if (d !== 16'h0000) begin
            $display("FAIL race_then_clear got %h want 0000", d); fails++;
        end
        tests++;
        @(negedge clk);
        src[4] = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        write_reg(4'd0, 16'h0003);
        write_reg(4'd1, 16'h0003);
        write_reg(4'd3, 16'h0004);
        write_reg(4'd4, 16'h0000);
        pulse(16'h0003);
        if (ext_int !== 4'h3) begin
            $display("FAIL rmid_setup got %h want 3", ext_int); fails++;
        end
        tests++;
        read_reg(4'd0, d);
        if (d !== 16'h0003) begin
            $display("FAIL rmid_read_enable got %h want 0003", d); fails++;
        end
        tests++;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        if (ext_int !== 4'h0) begin
            $display("FAIL rmid_ext_int got %h want 0", ext_int); fails++;
        end
        tests++;
        if (rdata !== 16'h0) begin
            $display("FAIL rmid_rdata got %h want 0", rdata); fails++;
        end
        tests++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 5; a++) begin
            read_reg(4'(a), d);
            if (d !== 16'h0) begin
                $display("FAIL rmid_reg%0d got %h want 0", a, d); fails++;
            end
            tests++;
        end
        write_reg(4'd0, 16'h0001);
        write_reg(4'd1, 16'h0001);
        @(negedge clk);
        src[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (ext_int !== 4'h0) begin
            $display("FAIL rmid_relatency_early got %h want 0", ext_int); fails++;
        end
        tests++;
        @(posedge clk);
        #1;
        if (ext_int !== 4'h1) begin
            $display("FAIL rmid_relatency got %h want 1", ext_int); fails++;
        end
        tests++;
        @(negedge clk);
        src[0] = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        src   = '0;
        addr  = '0;
        wdata = '0;
        we    = 1'b0;
        re    = 1'b0;
        test_reset;
        test_edge;
        test_level;
        test_round_robin;
        test_mask;
        test_race;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
